// File: rtl/sram_bd_pkg.sv
// Shared types and helpers for the byte-enable SRAM core and its backdoor path.
package sram_bd_pkg;

  // Backdoor access size encoding
  typedef enum logic [1:0] {
    BD_SZ8     = 2'd0,
    BD_SZ16    = 2'd1,
    BD_SZ32    = 2'd2,
    BD_SZ_RSVD = 2'd3
  } bd_size_t;

  localparam int BD_MAX_BYTES = 4;

  // Number of bytes touched by a backdoor access; the reserved size touches none
  function automatic logic [2:0] bd_num_bytes(input bd_size_t size);
    logic [2:0] n;
    case (size)
      BD_SZ8:  n = 3'd1;
      BD_SZ16: n = 3'd2;
      BD_SZ32: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Byte position (relative to the offset) holding data byte i of an n-byte access
  function automatic logic [1:0] bd_lane(input logic [1:0] i, input logic [2:0] n,
                                         input logic little_endian);
    return little_endian ? i : 2'(n - 3'd1 - {1'b0, i});
  endfunction

endpackage

// File: rtl/sram_bd_byte_map.sv
// Maps a backdoor offset/size/endianness to the storage byte address of each
// data byte, plus a mask of which data bytes take part in the access.
module sram_bd_byte_map
  import sram_bd_pkg::*;
#(
  parameter int BYTE_ADDR_W = 11
) (
  input  logic [BYTE_ADDR_W-1:0]                   offset,
  input  bd_size_t                                 size,
  input  logic                                     little_endian,
  output logic [BD_MAX_BYTES-1:0][BYTE_ADDR_W-1:0] byte_addr,
  output logic [BD_MAX_BYTES-1:0]                  lane_valid
);

  logic [2:0] num_bytes;

  assign num_bytes = bd_num_bytes(size);

  // Per data byte: address wraps naturally by truncation to BYTE_ADDR_W bits
  always_comb begin
    byte_addr  = '0;
    lane_valid = '0;
    for (int i = 0; i < BD_MAX_BYTES; i++) begin
      lane_valid[i] = (i < int'(num_bytes));
      byte_addr[i]  = offset + BYTE_ADDR_W'(bd_lane(2'(i), num_bytes, little_endian));
    end
  end

endmodule

// File: rtl/sram_byte_en_backdoor_core.sv
// Byte-addressed storage shared by a word-wide functional port with byte
// enables and a 32-bit backdoor port with selectable endianness.
module sram_byte_en_backdoor_core
  import sram_bd_pkg::*;
#(
  parameter  int ADDRESS_WIDTH = 7,
  parameter  int DATA_WIDTH    = 128,
  localparam int BYTES         = DATA_WIDTH / 8,
  localparam int BYTE_ADDR_W   = ADDRESS_WIDTH + $clog2(BYTES),
  localparam int MEM_BYTES     = 2 ** BYTE_ADDR_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic                     i_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [BYTES-1:0]         i_byte_enable,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  input  logic                     i_little_endian,
  input  logic                     i_bd_req,
  input  logic                     i_bd_write,
  input  logic [1:0]               i_bd_size,
  input  logic [BYTE_ADDR_W-1:0]   i_bd_offset,
  input  logic [31:0]              i_bd_wdata,
  output logic [31:0]              o_bd_rdata,
  output logic                     o_bd_ack,
  output logic [31:0]              o_mem_size
);

  logic [7:0] mem [MEM_BYTES];

  logic [BYTE_ADDR_W-1:0]                   func_base;
  logic [DATA_WIDTH-1:0]                    func_word;
  bd_size_t                                 bd_size;
  logic [BD_MAX_BYTES-1:0][BYTE_ADDR_W-1:0] bd_addr;
  logic [BD_MAX_BYTES-1:0]                  bd_lane_valid;
  logic [31:0]                              bd_word;
  logic                                     bd_wr_en;
  logic                                     bd_rd_update;

  assign func_base    = {i_address, {$clog2(BYTES){1'b0}}};
  assign bd_size      = bd_size_t'(i_bd_size);
  assign bd_wr_en     = i_bd_req & i_bd_write;
  // Reserved size reports zero read data even when flagged as a write
  assign bd_rd_update = i_bd_req & (~i_bd_write | (bd_size == BD_SZ_RSVD));
  assign o_mem_size   = 32'(MEM_BYTES);

  sram_bd_byte_map #(
    .BYTE_ADDR_W(BYTE_ADDR_W)
  ) u_byte_map (
    .offset       (i_bd_offset),
    .size         (bd_size),
    .little_endian(i_little_endian),
    .byte_addr    (bd_addr),
    .lane_valid   (bd_lane_valid)
  );

  // Gather the addressed functional word from storage
  always_comb begin
    func_word = '0;
    for (int k = 0; k < BYTES; k++) begin
      func_word[8*k +: 8] = mem[func_base + BYTE_ADDR_W'(k)];
    end
  end

  // Assemble backdoor read data right-aligned; unused lanes stay zero
  always_comb begin
    bd_word = '0;
    for (int i = 0; i < BD_MAX_BYTES; i++) begin
      if (bd_lane_valid[i]) begin
        bd_word[8*i +: 8] = mem[bd_addr[i]];
      end
    end
  end

  // Storage writes; backdoor is applied last so it wins a same-byte collision
  always_ff @(posedge i_clk) begin
    if (i_write_enable) begin
      for (int k = 0; k < BYTES; k++) begin
        if (i_byte_enable[k]) begin
          mem[func_base + BYTE_ADDR_W'(k)] <= i_write_data[8*k +: 8];
        end
      end
    end
    if (bd_wr_en) begin
      for (int i = 0; i < BD_MAX_BYTES; i++) begin
        if (bd_lane_valid[i]) begin
          mem[bd_addr[i]] <= i_bd_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read data and ack; reads see pre-edge storage contents
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_read_data <= '0;
      o_bd_rdata  <= '0;
      o_bd_ack    <= 1'b0;
    end else begin
      o_read_data <= i_write_enable ? '0 : func_word;
      o_bd_ack    <= i_bd_req;
      if (bd_rd_update) begin
        o_bd_rdata <= bd_word;
      end
    end
  end

endmodule

// File: tb/tb_sram_byte_en_backdoor_core.sv
// Scoreboard bench for sram_byte_en_backdoor_core: stimulus pushes expected
// responses, a negedge monitor pops them when the DUT presents a result.
module tb_sram_byte_en_backdoor_core;

  logic         i_clk;
  logic         i_reset;
  logic [127:0] i_write_data;
  logic         i_write_enable;
  logic [6:0]   i_address;
  logic [15:0]  i_byte_enable;
  logic [127:0] o_read_data;
  logic         i_little_endian;
  logic         i_bd_req;
  logic         i_bd_write;
  logic [1:0]   i_bd_size;
  logic [10:0]  i_bd_offset;
  logic [31:0]  i_bd_wdata;
  logic [31:0]  o_bd_rdata;
  logic         o_bd_ack;
  logic [31:0]  o_mem_size;

  sram_byte_en_backdoor_core dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_write_data   (i_write_data),
    .i_write_enable (i_write_enable),
    .i_address      (i_address),
    .i_byte_enable  (i_byte_enable),
    .o_read_data    (o_read_data),
    .i_little_endian(i_little_endian),
    .i_bd_req       (i_bd_req),
    .i_bd_write     (i_bd_write),
    .i_bd_size      (i_bd_size),
    .i_bd_offset    (i_bd_offset),
    .i_bd_wdata     (i_bd_wdata),
    .o_bd_rdata     (o_bd_rdata),
    .o_bd_ack       (o_bd_ack),
    .o_mem_size     (o_mem_size)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          chk;
    logic [31:0] val;
    string       name;
  } bd_exp_t;

  typedef struct {
    logic [127:0] val;
    logic [127:0] mask;
    string        name;
  } func_exp_t;

  bd_exp_t   bd_q[$];
  func_exp_t func_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ack_run = 0;
  int max_run = 0;

  logic func_rd_req;
  logic func_vld_q;

  localparam logic [127:0] W3   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] LO32 = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
  localparam logic [127:0] LO16 = 128'h0000_0000_0000_0000_0000_0000_0000_FFFF;
  localparam logic [127:0] HI8  = 128'hFF00_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] HI16 = 128'hFFFF_0000_0000_0000_0000_0000_0000_0000;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Functional result is presented one cycle after a tracked request
  always @(posedge i_clk) func_vld_q <= func_rd_req;

  // Monitor: compare DUT outputs against the scoreboard when they are presented
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_bd_ack) begin
        ack_run++;
        if (bd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL bd_ack_unexpected: got ack=1 expected no pending request");
        end else begin
          bd_exp_t e;
          e = bd_q.pop_front();
          if (e.chk) check32(e.name, o_bd_rdata, e.val);
        end
      end else begin
        if (ack_run > max_run) max_run = ack_run;
        ack_run = 0;
      end
      if (func_vld_q) begin
        n_tests++;
        if (func_q.size() == 0) begin
          n_fail++;
          $display("FAIL func_unexpected: got result with no pending request");
        end else begin
          func_exp_t f;
          f = func_q.pop_front();
          if (((o_read_data ^ f.val) & f.mask) != '0) begin
            n_fail++;
            $display("FAIL %s: got 0x%032h expected 0x%032h mask 0x%032h",
                     f.name, o_read_data, f.val, f.mask);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    i_write_enable = 1'b0;
    i_byte_enable  = '0;
    i_write_data   = '0;
    i_bd_req       = 1'b0;
    i_bd_write     = 1'b0;
    i_bd_size      = 2'd0;
    i_bd_wdata     = '0;
    func_rd_req    = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    clear_inputs();
  endtask

  // Present an operation for one cycle, then leave one idle cycle
  task automatic step();
    tick();
    tick();
  endtask

  task automatic set_func(input logic we, input logic [6:0] addr, input logic [127:0] wd,
                          input logic [15:0] be);
    i_write_enable = we;
    i_address      = addr;
    i_write_data   = wd;
    i_byte_enable  = be;
  endtask

  task automatic exp_func(input logic [127:0] v, input logic [127:0] m, input string name);
    func_exp_t f;
    f.val  = v;
    f.mask = m;
    f.name = name;
    func_q.push_back(f);
    func_rd_req = 1'b1;
  endtask

  task automatic set_bd(input logic wr, input logic [1:0] sz, input logic [10:0] off,
                        input logic [31:0] wd, input logic le, input bit chk,
                        input logic [31:0] v, input string name, input bit track = 1'b1);
    bd_exp_t e;
    i_bd_req        = 1'b1;
    i_bd_write      = wr;
    i_bd_size       = sz;
    i_bd_offset     = off;
    i_bd_wdata      = wd;
    i_little_endian = le;
    if (track) begin
      e.chk  = chk;
      e.val  = v;
      e.name = name;
      bd_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    i_address       = '0;
    i_bd_offset     = '0;
    i_little_endian = 1'b1;
    i_reset         = 1'b1;
    #2;
    check32("reset_read_data_lo", o_read_data[31:0], 32'h0);
    check32("reset_bd_rdata", o_bd_rdata, 32'h0);
    check32("reset_bd_ack", {31'b0, o_bd_ack}, 32'h0);
    check32("mem_size", o_mem_size, 32'd2048);
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    tick();

    // Functional byte enables on word 3
    set_func(1'b1, 7'd3, W3, 16'hFFFF);       exp_func('0, ONES, "wr_full_returns_zero");          step();
    set_func(1'b1, 7'd3, ONES, 16'h0001);     exp_func('0, ONES, "wr_be1_returns_zero");           step();
    set_func(1'b0, 7'd3, '0, '0);             exp_func(W3, ONES, "rd_word3");                      step();
    set_func(1'b1, 7'd3, ONES, 16'h0000);     exp_func('0, ONES, "wr_be0_returns_zero");           step();
    set_func(1'b0, 7'd3, '0, '0);             exp_func(W3, ONES, "rd_word3_after_be0");            step();
    set_func(1'b1, 7'd3, '0, 16'h0002);       exp_func('0, ONES, "wr_be2_returns_zero");           step();
    set_func(1'b0, 7'd3, '0, '0);
    exp_func(128'h00112233_44556677_8899AABB_CCDD00FF, ONES, "rd_word3_byte1_cleared");             step();

    // Little-endian backdoor write, seen through both ports
    set_bd(1'b1, 2'd2, 11'h010, 32'hDEADBEEF, 1'b1, 1'b0, '0, "le_wr32");                          step();
    set_func(1'b0, 7'd1, '0, '0);             exp_func(128'hDEADBEEF, LO32, "le_func_word1");      step();
    set_bd(1'b0, 2'd0, 11'h010, '0, 1'b1, 1'b1, 32'h000000EF, "le_rd8");                           step();

    // Big-endian backdoor write
    set_bd(1'b1, 2'd2, 11'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, "be_wr32");                          step();
    set_bd(1'b0, 2'd0, 11'h010, '0, 1'b0, 1'b1, 32'h000000DE, "be_rd8");                           step();
    set_bd(1'b0, 2'd1, 11'h010, '0, 1'b0, 1'b1, 32'h0000DEAD, "be_rd16");                          step();
    set_bd(1'b0, 2'd2, 11'h010, '0, 1'b0, 1'b1, 32'hDEADBEEF, "be_rd32");                          step();
    set_bd(1'b0, 2'd2, 11'h010, '0, 1'b1, 1'b1, 32'hEFBEADDE, "be_data_le_rd32");                  step();
    set_func(1'b0, 7'd1, '0, '0);             exp_func(128'hEFBEADDE, LO32, "be_func_word1");      step();

    // Unaligned write straddling words 0 and 1
    set_bd(1'b1, 2'd1, 11'h00F, 32'hFFFFA55A, 1'b1, 1'b0, '0, "unal_wr16");                        step();
    set_bd(1'b0, 2'd0, 11'h00F, '0, 1'b1, 1'b1, 32'h0000005A, "unal_byte0f");                      step();
    set_bd(1'b0, 2'd0, 11'h010, '0, 1'b1, 1'b1, 32'h000000A5, "unal_byte10");                      step();
    set_bd(1'b0, 2'd1, 11'h00F, '0, 1'b0, 1'b1, 32'h00005AA5, "unal_be_rd16");                     step();
    set_func(1'b0, 7'd0, '0, '0);             exp_func(128'h5A << 120, HI8, "unal_func_word0");    step();

    // Write wrapping from the top of storage back to byte 0
    set_bd(1'b1, 2'd2, 11'd2046, 32'h11223344, 1'b1, 1'b0, '0, "wrap_wr32");                       step();
    set_bd(1'b0, 2'd0, 11'd2046, '0, 1'b1, 1'b1, 32'h00000044, "wrap_b2046");                      step();
    set_bd(1'b0, 2'd0, 11'd2047, '0, 1'b1, 1'b1, 32'h00000033, "wrap_b2047");                      step();
    set_bd(1'b0, 2'd0, 11'd0,    '0, 1'b1, 1'b1, 32'h00000022, "wrap_b0");                         step();
    set_bd(1'b0, 2'd0, 11'd1,    '0, 1'b1, 1'b1, 32'h00000011, "wrap_b1");                         step();
    set_bd(1'b0, 2'd2, 11'd2046, '0, 1'b1, 1'b1, 32'h11223344, "wrap_rd32");                       step();
    set_func(1'b0, 7'd127, '0, '0);           exp_func(128'h3344 << 112, HI16, "wrap_func_w127");  step();
    set_func(1'b0, 7'd0, '0, '0);
    exp_func((128'h5A << 120) | 128'h1122, HI8 | LO16, "wrap_func_w0");                            step();

    // Same-edge collision on byte 0: backdoor wins
    set_func(1'b1, 7'd0, 128'hAA, 16'h0001);  exp_func('0, ONES, "coll_func_wr_zero");
    set_bd(1'b1, 2'd0, 11'd0, 32'h00000055, 1'b1, 1'b0, '0, "coll_bd_wr8");                        step();
    set_bd(1'b0, 2'd0, 11'd0, '0, 1'b1, 1'b1, 32'h00000055, "coll_rd8");                           step();

    // Three back-to-back requests
    set_bd(1'b0, 2'd0, 11'h010, '0, 1'b1, 1'b1, 32'h000000A5, "b2b_rd0");                          tick();
    set_bd(1'b0, 2'd0, 11'h011, '0, 1'b1, 1'b1, 32'h000000AD, "b2b_rd1");                          tick();
    set_bd(1'b0, 2'd0, 11'h012, '0, 1'b1, 1'b1, 32'h000000BE, "b2b_rd2");                          step();

    // Reserved size: ack, zero read data, no storage change
    set_bd(1'b0, 2'd3, 11'h010, '0, 1'b1, 1'b1, 32'h0, "rsvd_rd");                                 step();
    set_bd(1'b0, 2'd2, 11'h010, '0, 1'b1, 1'b1, 32'hEFBEADA5, "pre_rsvd_wr_rd32");                 step();
    set_bd(1'b1, 2'd3, 11'h010, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, "rsvd_wr");                       step();
    set_bd(1'b0, 2'd2, 11'h010, '0, 1'b1, 1'b1, 32'hEFBEADA5, "post_rsvd_wr_rd32");                step();

    // Reset asserted mid-cycle with outputs live
    set_func(1'b0, 7'd3, '0, '0);
    set_bd(1'b0, 2'd2, 11'h010, '0, 1'b1, 1'b0, '0, "untracked", 1'b0);
    tick();
    check32("pre_reset_ack", {31'b0, o_bd_ack}, 32'h1);
    #1;
    i_reset = 1'b1;
    #1;
    check32("midreset_read_data_lo", o_read_data[31:0], 32'h0);
    check32("midreset_read_data_hi", o_read_data[127:96], 32'h0);
    check32("midreset_bd_rdata", o_bd_rdata, 32'h0);
    check32("midreset_bd_ack", {31'b0, o_bd_ack}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (3) tick();

    check32("bd_queue_drained", bd_q.size(), 32'd0);
    check32("func_queue_drained", func_q.size(), 32'd0);
    check32("b2b_ack_run", max_run, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
